// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch sequencer: fetches via req/ack, issues to decode via
// valid/ready, then steps or redirects the PC on each accepted instruction.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] branch_off,
  input  logic [25:0] jump_idx,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_ERROR
  } state_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;

  always_comb begin
    seq_pc  = ipc_q + 32'd4;
    next_pc = seq_pc;
    if (redirect) begin
      unique case (redirect_kind)
        2'b00:   next_pc = seq_pc + {branch_off[29:0], 2'b00};
        2'b01:   next_pc = {seq_pc[31:28], jump_idx, 2'b00};
        2'b10:   next_pc = {jr_target[31:2], 2'b00};
        default: next_pc = seq_pc;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          wait_d  = 8'd0;
          state_d = S_ISSUE;
        end else if (wait_q == MaxWait) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign pc          = pc_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: memory/decode model with a fetch scoreboard.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [1:0]  redirect_kind = 2'b00;
  logic [31:0] branch_off = 32'd0;
  logic [25:0] jump_idx = 26'd0;
  logic [31:0] jr_target = 32'd0;
  logic [31:0] pc;
  logic        fetch_err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_t;

  fetch_t      sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_instr;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_kind(redirect_kind),
    .branch_off(branch_off), .jump_idx(jump_idx),
    .jr_target(jr_target), .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_next(
    input logic [31:0] ipc, input logic rd, input logic [1:0] k,
    input logic [31:0] boff, input logic [25:0] jidx,
    input logic [31:0] jrt);
    logic [31:0] s;
    s = ipc + 32'd4;
    if (!rd) return s;
    case (k)
      2'b00:   return s + (boff << 2);
      2'b01:   return {s[31:28], jidx, 2'b00};
      2'b10:   return jrt & 32'hFFFF_FFFC;
      default: return s;
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 ||
        pc !== 32'd0 || imem_addr !== 32'd0 || instr !== 32'd0 ||
        instr_pc !== 32'd0) begin
      errors++;
      $display("FAIL %s: req=%b vld=%b err=%b pc=%h addr=%h instr=%h ipc=%h want all zero",
               tag, imem_req, instr_valid, fetch_err, pc, imem_addr,
               instr, instr_pc);
    end
  endtask

  // Caller sits at a negedge with the DUT in FETCH on address a.
  task automatic do_fetch(input int waits, input logic [31:0] a);
    fetch_t f;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_req: req=%b addr=%h vld=%b want req=1 addr=%h vld=0",
               imem_req, imem_addr, instr_valid, a);
    end
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== a || fetch_err !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait%0d: req=%b addr=%h err=%b want 1/%h/0",
                 i, imem_req, imem_addr, fetch_err, a);
      end
    end
    f.addr = a;
    f.data = $urandom;
    sb.push_back(f);
    imem_ack   = 1'b1;
    imem_rdata = f.data;
    last_instr = f.data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic do_issue(input int stall, input logic rd,
                          input logic [1:0] k, input logic [31:0] boff,
                          input logic [25:0] jidx, input logic [31:0] jrt);
    fetch_t f;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL issue_sb: scoreboard empty, want one entry");
      return;
    end
    f = sb.pop_front();
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 ||
        instr !== f.data || instr_pc !== f.addr) begin
      errors++;
      $display("FAIL issue: vld=%b req=%b instr=%h ipc=%h want 1/0/%h/%h",
               instr_valid, imem_req, instr, instr_pc, f.data, f.addr);
    end
    for (int i = 0; i < stall; i++) begin
      instr_ready   = 1'b0;
      redirect      = 1'b1;
      redirect_kind = 2'b01;
      jump_idx      = 26'h3FF_FFFF;
      imem_ack      = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== f.data ||
          instr_pc !== f.addr || pc !== f.addr) begin
        errors++;
        $display("FAIL stall%0d: vld=%b req=%b instr=%h ipc=%h pc=%h want 1/0/%h/%h/%h",
                 i, instr_valid, imem_req, instr, instr_pc, pc,
                 f.data, f.addr, f.addr);
      end
    end
    exp_pc        = model_next(f.addr, rd, k, boff, jidx, jrt);
    instr_ready   = 1'b1;
    redirect      = rd;
    redirect_kind = k;
    branch_off    = boff;
    jump_idx      = jidx;
    jr_target     = jrt;
    @(negedge clk);
    instr_ready = 1'b0;
    redirect    = 1'b0;
    checks++;
    if (pc !== exp_pc || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL next_pc: pc=%h vld=%b want pc=%h vld=0",
               pc, instr_valid, exp_pc);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1 chk_reset_vals("reset_async");
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset_hold");
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req: req=%b want 0", imem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      do_fetch(0, 32'(i * 4));
      do_issue(0, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0);
    end
  endtask

  task automatic test_stall();
    do_fetch(0, 32'h10);
    do_issue(5, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0);
  endtask

  task automatic test_redirect();
    do_fetch(0, 32'h14);
    do_issue(0, 1'b1, 2'b10, 32'd0, 26'd0, 32'h103);
    do_fetch(0, 32'h100);
    do_issue(0, 1'b1, 2'b00, 32'hFFFF_FFFE, 26'd0, 32'd0);
    do_fetch(0, 32'hFC);
    do_issue(0, 1'b1, 2'b01, 32'd0, 26'h40, 32'd0);
    do_fetch(0, 32'h100);
    do_issue(0, 1'b1, 2'b10, 32'd0, 26'd0, 32'h2003);
    do_fetch(0, 32'h2000);
    do_issue(0, 1'b1, 2'b11, 32'h100, 26'h55, 32'h8000);
  endtask

  task automatic test_wait();
    do_fetch(3, 32'h2004);
    do_issue(0, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0);
  endtask

  task automatic test_async_reset();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2008) begin
      errors++;
      $display("FAIL pre_reset: req=%b addr=%h want 1/00002008",
               imem_req, imem_addr);
    end
    @(negedge clk);
    #3 rst = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1 chk_reset_vals("reset_midfetch");
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr !== 32'd0 || instr_valid !== 1'b0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL late_ack: instr=%h vld=%b addr=%h want 0/0/0",
               instr, instr_valid, imem_addr);
    end
    do_fetch(0, 32'h0);
    do_issue(0, 1'b1, 2'b10, 32'd0, 26'd0, 32'hFFFF_FFFF);
  endtask

  task automatic test_wrap();
    do_fetch(15, 32'hFFFF_FFFC);
    do_issue(0, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0 || imem_addr !== 32'd0) begin
        errors++;
        $display("FAIL timeout_cyc%0d: req=%b err=%b addr=%h want 1/0/0",
                 i, imem_req, fetch_err, imem_addr);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          instr !== last_instr) begin
        errors++;
        $display("FAIL error_state%0d: err=%b req=%b vld=%b instr=%h want 1/0/0/%h",
                 i, fetch_err, imem_req, instr_valid, instr, last_instr);
      end
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      @(negedge clk);
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wait();
    test_async_reset();
    test_wrap();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
